// File: rtl/mbus_tx_msg_queue_pkg.sv
// Shared widths, queue entry layout and FSM state encoding for the TX message queue.
package mbus_tx_msg_queue_pkg;

  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned TXQ_ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH + 1;

  typedef enum logic [2:0] {
    TXQ_ST_IDLE  = 3'd0,
    TXQ_ST_REQ   = 3'd1,
    TXQ_ST_WACK  = 3'd2,
    TXQ_ST_WRESP = 3'd3,
    TXQ_ST_RACK  = 3'd4,
    TXQ_ST_DRAIN = 3'd5
  } txq_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } txq_entry_t;

endpackage

// File: rtl/mbus_tx_msg_queue_ram.sv
// Queue storage: one synchronous write port, one asynchronous read port, no reset on the array.
module mbus_txq_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mbus_tx_msg_queue.sv
// Buffers whole messages and replays them on the node TX handshake, retrying failed
// messages up to MAX_RETRY times before discarding them.
module mbus_tx_msg_queue
  import mbus_tx_msg_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                  CLKIN,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_LAST,
  input  logic                  WR_PRIO,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_PEND,
  output logic                  TX_REQ,
  input  logic                  TX_ACK,
  output logic                  TX_PRIORITY,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK,
  output logic                  MSG_DONE,
  output logic                  MSG_ERR,
  output logic                  BUSY
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  txq_state_t    state;
  logic [PW-1:0] wr_ptr, rd_ptr, cmt_ptr, count, msg_cnt;
  logic [RW-1:0] retry_cnt;
  logic          cur_last, msg_end, resp_fail;
  logic          wr_fire, msg_inc, msg_dec;
  logic          prio_mem [DEPTH];
  txq_entry_t    wr_entry, rd_entry;

  always_comb begin
    wr_entry      = '0;
    wr_entry.addr = WR_ADDR;
    wr_entry.data = WR_DATA;
    wr_entry.last = WR_LAST;
  end

  mbus_txq_ram #(
    .DEPTH(DEPTH),
    .WIDTH(TXQ_ENTRY_WIDTH)
  ) u_ram (
    .clk    (CLKIN),
    .wr_en  (wr_fire),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_data(wr_entry),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_data(rd_entry)
  );

  // Space is reclaimed only at commit/discard so a failed message can be replayed.
  assign count    = wr_ptr - cmt_ptr;
  assign WR_READY = (count != PW'(DEPTH));
  assign wr_fire  = WR_VALID & WR_READY;
  assign msg_inc  = wr_fire & WR_LAST;
  assign BUSY     = (state != TXQ_ST_IDLE) || (msg_cnt != '0);

  always_comb begin
    msg_dec = 1'b0;
    if (state == TXQ_ST_RACK && !TX_SUCC && !TX_FAIL && !resp_fail) msg_dec = 1'b1;
    if (state == TXQ_ST_DRAIN && msg_end) msg_dec = 1'b1;
  end

  always_ff @(posedge CLKIN) begin
    if (wr_fire) prio_mem[wr_ptr[AW-1:0]] <= WR_PRIO;
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      wr_ptr  <= '0;
      msg_cnt <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
      msg_cnt <= msg_cnt + PW'(msg_inc) - PW'(msg_dec);
    end
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state       <= TXQ_ST_IDLE;
      rd_ptr      <= '0;
      cmt_ptr     <= '0;
      retry_cnt   <= '0;
      cur_last    <= 1'b0;
      msg_end     <= 1'b0;
      resp_fail   <= 1'b0;
      TX_ADDR     <= '0;
      TX_DATA     <= '0;
      TX_PEND     <= 1'b0;
      TX_REQ      <= 1'b0;
      TX_PRIORITY <= 1'b0;
      TX_RESP_ACK <= 1'b0;
      MSG_DONE    <= 1'b0;
      MSG_ERR     <= 1'b0;
    end else begin
      MSG_DONE <= 1'b0;
      MSG_ERR  <= 1'b0;
      case (state)
        TXQ_ST_IDLE: begin
          if (msg_cnt != '0) begin
            TX_ADDR     <= rd_entry.addr;
            TX_DATA     <= rd_entry.data;
            TX_PEND     <= ~rd_entry.last;
            TX_PRIORITY <= prio_mem[rd_ptr[AW-1:0]];
            TX_REQ      <= 1'b1;
            cur_last    <= rd_entry.last;
            msg_end     <= 1'b0;
            state       <= TXQ_ST_REQ;
          end
        end
        TXQ_ST_REQ: begin
          if (TX_ACK) begin
            rd_ptr <= rd_ptr + PW'(1);
            if (cur_last) msg_end <= 1'b1;
          end
          if (TX_FAIL) begin
            TX_REQ <= 1'b0;
            state  <= TXQ_ST_WRESP;
          end else if (TX_ACK) begin
            TX_REQ <= 1'b0;
            state  <= TXQ_ST_WACK;
          end
        end
        TXQ_ST_WACK: begin
          if (TX_FAIL) begin
            state <= TXQ_ST_WRESP;
          end else if (!TX_ACK) begin
            if (cur_last) begin
              state <= TXQ_ST_WRESP;
            end else begin
              TX_DATA  <= rd_entry.data;
              TX_PEND  <= ~rd_entry.last;
              TX_REQ   <= 1'b1;
              cur_last <= rd_entry.last;
              state    <= TXQ_ST_REQ;
            end
          end
        end
        TXQ_ST_WRESP: begin
          if (TX_SUCC || TX_FAIL) begin
            TX_RESP_ACK <= 1'b1;
            resp_fail   <= TX_FAIL;
            state       <= TXQ_ST_RACK;
          end
        end
        TXQ_ST_RACK: begin
          if (!TX_SUCC && !TX_FAIL) begin
            TX_RESP_ACK <= 1'b0;
            if (!resp_fail) begin
              cmt_ptr   <= rd_ptr;
              retry_cnt <= '0;
              MSG_DONE  <= 1'b1;
              state     <= TXQ_ST_IDLE;
            end else if (retry_cnt < RW'(MAX_RETRY)) begin
              rd_ptr    <= cmt_ptr;
              retry_cnt <= retry_cnt + RW'(1);
              state     <= TXQ_ST_IDLE;
            end else begin
              state <= TXQ_ST_DRAIN;
            end
          end
        end
        TXQ_ST_DRAIN: begin
          // An abort may leave rd_ptr mid-message; step past the remaining words.
          if (msg_end) begin
            cmt_ptr   <= rd_ptr;
            retry_cnt <= '0;
            MSG_ERR   <= 1'b1;
            state     <= TXQ_ST_IDLE;
          end else begin
            rd_ptr <= rd_ptr + PW'(1);
            if (rd_entry.last) msg_end <= 1'b1;
          end
        end
        default: state <= TXQ_ST_IDLE;
      endcase
    end
  end

  // A full queue holding no complete message can never drain: message longer than DEPTH.
  assert property (@(posedge CLKIN) disable iff (RESET)
    !(count == PW'(DEPTH) && msg_cnt == '0));

endmodule

// File: tb/tb_mbus_tx_msg_queue.sv
// Directed and randomized bench: a node model drives the TX handshake and each word is
// compared against the message list the bench wrote, with retry/discard outcomes predicted.
module tb_mbus_tx_msg_queue;
  import mbus_tx_msg_queue_pkg::*;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned MAX_RETRY = 3;

  typedef struct packed {
    logic [31:0]      addr;
    logic             prio;
    logic [3:0]       len;
    logic [7:0][31:0] data;
  } msg_t;

  logic                  CLKIN = 1'b0;
  logic                  RESET;
  logic [ADDR_WIDTH-1:0] WR_ADDR;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_LAST, WR_PRIO, WR_VALID, WR_READY;
  logic [ADDR_WIDTH-1:0] TX_ADDR;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_PEND, TX_REQ, TX_ACK, TX_PRIORITY;
  logic                  TX_SUCC, TX_FAIL, TX_RESP_ACK, MSG_DONE, MSG_ERR, BUSY;

  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
  logic ready_hi, ready_lo;

  always #5 CLKIN = ~CLKIN;

  mbus_tx_msg_queue #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
    .CLKIN(CLKIN), .RESET(RESET),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_LAST(WR_LAST), .WR_PRIO(WR_PRIO),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
    .TX_ACK(TX_ACK), .TX_PRIORITY(TX_PRIORITY), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
    .TX_RESP_ACK(TX_RESP_ACK), .MSG_DONE(MSG_DONE), .MSG_ERR(MSG_ERR), .BUSY(BUSY)
  );

  always @(negedge CLKIN) begin
    if (MSG_DONE) done_cnt++;
    if (MSG_ERR) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic msg_t mk(input logic [31:0] a, input logic p, input int len,
                              input logic [31:0] d0, d1, d2, d3);
    msg_t m;
    m = '0;
    m.addr = a; m.prio = p; m.len = 4'(len);
    m.data[0] = d0; m.data[1] = d1; m.data[2] = d2; m.data[3] = d3;
    return m;
  endfunction

  function automatic msg_t rnd_msg();
    msg_t m;
    m = '0;
    m.addr = $urandom;
    m.prio = 1'($urandom_range(0, 1));
    m.len  = 4'($urandom_range(1, 4));
    for (int i = 0; i < 8; i++) m.data[i] = $urandom;
    return m;
  endfunction

  // Later words carry junk address/priority: only the first word's values may reach TX.
  task automatic write_msg(input msg_t m);
    for (int w = 0; w < int'(m.len); w++) begin
      int n = 0;
      WR_ADDR  = (w == 0) ? m.addr : $urandom;
      WR_PRIO  = (w == 0) ? m.prio : 1'($urandom_range(0, 1));
      WR_DATA  = m.data[w];
      WR_LAST  = (w == int'(m.len) - 1);
      WR_VALID = 1'b1;
      while (!WR_READY && n < 300) begin @(negedge CLKIN); n++; end
      if (!WR_READY) chk("wr_ready_timeout", 64'(WR_READY), 64'(1));
      @(negedge CLKIN);
    end
    WR_VALID = 1'b0;
  endtask

  task automatic get_word(input bit abort, output bit ok, output logic [31:0] a, d,
                          output logic pend, prio, output int drop);
    int n = 0;
    ok = 0; a = '0; d = '0; pend = 0; prio = 0; drop = 0;
    while (!TX_REQ && n < 300) begin @(negedge CLKIN); n++; end
    if (!TX_REQ) return;
    ok = 1; a = TX_ADDR; d = TX_DATA; pend = TX_PEND; prio = TX_PRIORITY;
    if (abort) begin
      TX_FAIL = 1'b1;
    end else begin
      TX_ACK = 1'b1;
      @(negedge CLKIN);
      drop = 1;
      while (TX_REQ && drop < 300) begin @(negedge CLKIN); drop++; end
      TX_ACK = 1'b0;
    end
  endtask

  task automatic give_resp(input bit succ);
    int n = 0;
    if (succ) TX_SUCC = 1'b1; else TX_FAIL = 1'b1;
    while (!TX_RESP_ACK && n < 300) begin @(negedge CLKIN); n++; end
    chk("resp_ack_rise", 64'(TX_RESP_ACK), 64'(1));
    chk("busy_in_resp", 64'(BUSY), 64'(1));
    TX_SUCC = 1'b0; TX_FAIL = 1'b0;
    n = 0;
    ready_hi = WR_READY;
    while (TX_RESP_ACK && n < 300) begin ready_hi = WR_READY; @(negedge CLKIN); n++; end
    ready_lo = WR_READY;
    chk("resp_ack_fall", 64'(TX_RESP_ACK), 64'(0));
  endtask

  task automatic tx_attempt(input msg_t m, input int abort_at, input bit succ, input string tag);
    bit ok; logic [31:0] a, d; logic pend, prio; int drop;
    for (int w = 0; w < int'(m.len); w++) begin
      get_word(w == abort_at, ok, a, d, pend, prio, drop);
      if (!ok) begin chk({tag, "_req_timeout"}, 64'(0), 64'(1)); return; end
      chk({tag, "_addr"}, 64'(a), 64'(m.addr));
      chk({tag, "_data"}, 64'(d), 64'(m.data[w]));
      chk({tag, "_pend"}, 64'(pend), 64'(w != int'(m.len) - 1));
      chk({tag, "_prio"}, 64'(prio), 64'(m.prio));
      if (w == abort_at) break;
      chk({tag, "_req_one_cycle"}, 64'(drop), 64'(1));
    end
    give_resp(succ);
  endtask

  // Reference: nfail failures are replayed up to MAX_RETRY times, then the message is dropped.
  task automatic run_msg(input msg_t m, input int nfail, input int abort_at, input string tag);
    int fa = (nfail > int'(MAX_RETRY)) ? int'(MAX_RETRY) + 1 : nfail;
    for (int k = 0; k < fa; k++) tx_attempt(m, abort_at, 1'b0, tag);
    if (nfail <= int'(MAX_RETRY)) begin
      tx_attempt(m, -1, 1'b1, tag);
      exp_done++;
    end else begin
      exp_err++;
    end
    repeat (10) @(negedge CLKIN);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
  endtask

  initial begin
    msg_t m, m2;
    bit ok; logic [31:0] a, d; logic pend, prio; int drop, n;
    RESET = 1'b1; WR_ADDR = '0; WR_DATA = '0; WR_LAST = 0; WR_PRIO = 0; WR_VALID = 0;
    TX_ACK = 0; TX_SUCC = 0; TX_FAIL = 0;
    repeat (3) @(negedge CLKIN);
    chk("rst_tx_req", 64'(TX_REQ), 64'(0));
    chk("rst_wr_ready", 64'(WR_READY), 64'(1));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_outs", 64'({TX_PEND, TX_PRIORITY, TX_RESP_ACK, MSG_DONE, MSG_ERR}), 64'(0));
    chk("rst_tx_addr_data", 64'({TX_ADDR, TX_DATA}), 64'(0));
    RESET = 1'b0;
    @(negedge CLKIN);

    m = mk(32'h12, 1'b0, 1, 32'hDEADBEEF, 0, 0, 0);
    write_msg(m);
    run_msg(m, 0, -1, "one_word");
    chk("one_word_ready_kept", 64'({ready_hi, ready_lo}), 64'(2'b11));
    chk("one_word_idle", 64'(BUSY), 64'(0));

    m = mk(32'hA5, 1'b1, 3, 1, 2, 3, 0);
    write_msg(m);
    run_msg(m, 0, -1, "three_word");
    chk("three_word_idle", 64'(BUSY), 64'(0));

    m = mk(32'h3C, 1'b0, 2, 32'h11, 32'h22, 0, 0);
    write_msg(m);
    run_msg(m, 2, -1, "retry2");

    m  = mk(32'h77, 1'b1, 4, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    m2 = mk(32'h78, 1'b0, 2, 32'hB1, 32'hB2, 0, 0);
    write_msg(m);
    write_msg(m2);
    run_msg(m, 4, 1, "abort_drain");
    run_msg(m2, 0, -1, "after_drain");

    m  = mk(32'h40, 1'b0, 4, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
    m2 = mk(32'h41, 1'b1, 4, 32'hD1, 32'hD2, 32'hD3, 32'hD4);
    write_msg(m);
    write_msg(m2);
    chk("fill_ready_low", 64'(WR_READY), 64'(0));
    run_msg(m, 0, -1, "fill_first");
    chk("fill_ready_rise", 64'({ready_hi, ready_lo}), 64'(2'b01));
    run_msg(m2, 0, -1, "fill_second");

    for (int i = 0; i < 8; i++) begin
      int nf, ab;
      m  = rnd_msg();
      nf = $urandom_range(0, 4);
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(0, int'(m.len) - 1) : -1;
      write_msg(m);
      run_msg(m, nf, ab, "rand");
    end
    chk("rand_idle", 64'(BUSY), 64'(0));

    m = mk(32'h99, 1'b0, 2, 32'hE1, 32'hE2, 0, 0);
    write_msg(m);
    get_word(1'b0, ok, a, d, pend, prio, drop);
    chk("rst_mid_word1", 64'(d), 64'(32'hE1));
    n = 0;
    while (!TX_REQ && n < 300) begin @(negedge CLKIN); n++; end
    chk("rst_mid_word2_req", 64'({TX_REQ, TX_DATA}), 64'({1'b1, 32'hE2}));
    RESET = 1'b1;
    #1;
    chk("rst_mid_req_drop", 64'(TX_REQ), 64'(0));
    chk("rst_mid_busy", 64'(BUSY), 64'(0));
    chk("rst_mid_ready", 64'(WR_READY), 64'(1));
    @(negedge CLKIN);
    RESET = 1'b0;
    repeat (20) @(negedge CLKIN);
    chk("rst_mid_no_req", 64'(TX_REQ), 64'(0));
    chk("rst_mid_counts", 64'({done_cnt, err_cnt}), 64'({exp_done, exp_err}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
